grf_sb: RTL

Parametrised general register file with an integrated pending-write scoreboard, replacing the fixed 32x32, 2-read-port register file in the decode stage. It provides NREAD combinational read ports, one synchronous write port, and per-register pending-write counters. The counters let the hazard unit stall on registers that still have writes in flight. Register 0 reads as zero and is never busy.

---
 rtl/grf_sb.sv | 123 ++++++++++++
 1 files changed

// File: rtl/grf_sb.sv
// grf_sb: general register file with an integrated pending-write scoreboard.
//
// Register 0 is not stored; it always reads as zero and is never busy.
// Registers 1..2**ADDR_W-1 are written synchronously from the writeback port.
// Each stored register has a saturating pending-write counter:
//   - SetBusy/SetAddr reserves a register (counter + 1).
//   - A write (WE/A3) retires one reservation (counter - 1, floored at 0).
//   - Overflow is a sticky flag, set when a reservation is dropped on a saturated counter.
//
// Optional feature (macro GRF_BYPASS_EN):
//   - A same-cycle write to RA_i is forwarded to RD_i.
//   - RBusy_i treats the retiring write as already done.
//
// Ports:
//   Clk       rising-edge clock
//   Reset_n   synchronous active-low reset
//   WE/A3/WD  write port (write enable, address, data)
//   RA        NREAD packed read addresses, port i at RA[i*ADDR_W +: ADDR_W]
//   RD        NREAD packed read data,      port i at RD[i*DATA_W +: DATA_W]
//   RBusy     per-port pending-write indication
//   SetBusy   reserve strobe for SetAddr
//   SetAddr   register being reserved
//   Overflow  sticky saturation flag
module grf_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned PEND_W = 2
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      WE,
  input  logic [ADDR_W-1:0]         A3,
  input  logic [DATA_W-1:0]         WD,
  input  logic [NREAD*ADDR_W-1:0]   RA,
  output logic [NREAD*DATA_W-1:0]   RD,
  output logic [NREAD-1:0]          RBusy,
  input  logic                      SetBusy,
  input  logic [ADDR_W-1:0]         SetAddr,
  output logic                      Overflow
);

  localparam int unsigned       Depth  = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] CntMax = {PEND_W{1'b1}};

  logic [DATA_W-1:0] regs_q [1:Depth-1];
  logic [PEND_W-1:0] cnt_q  [1:Depth-1];
  logic [PEND_W-1:0] cnt_d  [1:Depth-1];
  logic              ovf_q, ovf_d;

  logic wr_en, rsv_en;

  assign wr_en  = WE && (A3 != '0);
  assign rsv_en = SetBusy && (SetAddr != '0);

  // Counter next state. A reserve and a retire on the same register cancel.
  // The one exception is an idle counter: its retire is ignored, so the result is 1.
  always_comb begin
    ovf_d = ovf_q;
    for (int unsigned r = 1; r < Depth; r++) begin
      cnt_d[r] = cnt_q[r];
      if (rsv_en && (SetAddr == ADDR_W'(r))) begin
        if (wr_en && (A3 == ADDR_W'(r))) begin
          if (cnt_q[r] == '0) begin
            cnt_d[r] = PEND_W'(1);
          end
        end else if (cnt_q[r] == CntMax) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + PEND_W'(1);
        end
      end else if (wr_en && (A3 == ADDR_W'(r)) && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int unsigned r = 1; r < Depth; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      if (wr_en) begin
        regs_q[A3] <= WD;
      end
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign Overflow = ovf_q;

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              busy;

    assign ra = RA[gi*ADDR_W +: ADDR_W];

    always_comb begin
      rd   = '0;
      busy = 1'b0;
      if (ra != '0) begin
        rd   = regs_q[ra];
        busy = (cnt_q[ra] != '0);
`ifdef GRF_BYPASS_EN
        // The retiring write is counted as done, so one outstanding reservation reads as idle.
        if (wr_en && (A3 == ra)) begin
          rd   = WD;
          busy = (cnt_q[ra] > PEND_W'(1));
        end
`endif
      end
    end

    assign RD[gi*DATA_W +: DATA_W] = rd;
    assign RBusy[gi]               = busy;
  end

endmodule
